// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between an ALU exerciser client and
// the alu_cmd_sequencer. The client side drives commands and consumes
// responses (master); the sequencer accepts commands and produces
// responses (slave).
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_op;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_mismatch;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_mismatch
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_mismatch
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU exerciser front end: accepts one command at a time, drives it into an
// external ALU, samples the ALU outputs a fixed number of cycles later,
// compares them with an internal reference model and returns the sampled
// values plus a mismatch flag. Mismatching responses are counted in a
// saturating error counter that only reset clears.
module alu_cmd_sequencer #(
  parameter int WIDTH       = 4,
  parameter int ALU_LAT     = 1,
  parameter int CHECK_CARRY = 1,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]    alu_a_o,
  output logic [WIDTH-1:0]    alu_b_o,
  output logic [2:0]          alu_op_o,
  input  logic [WIDTH-1:0]    alu_result_i,
  input  logic                alu_carry_i,
  output logic [CNT_W-1:0]    err_count_o
);

  // Wait counter is 4 bits wide because the latency is limited to 1..15.
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);
  localparam logic       CHK_C    = (CHECK_CARRY != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Reference model: returns {expected carry, expected result}.
  function automatic logic [WIDTH:0] ref_model(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {(a < b), a - b};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      3'b101:  r = {1'b0, ~a};
      3'b110:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      3'b111:  r = {a[0], 1'b0, a[WIDTH-1:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH:0]   exp_q, exp_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_mismatch_q, rsp_mismatch_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             mismatch_s;

  // Next-state and datapath decode for the IDLE/WAIT/RESP command sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    exp_d          = exp_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_op_d       = rsp_op_q;
    rsp_result_d   = rsp_result_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_mismatch_d = rsp_mismatch_q;
    err_d          = err_q;
    mismatch_s     = (alu_result_i != exp_q[WIDTH-1:0]) |
                     (CHK_C & (alu_carry_i != exp_q[WIDTH]));

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          alu_a_d  = bus.cmd_a;
          alu_b_d  = bus.cmd_b;
          alu_op_d = bus.cmd_op;
          exp_d    = ref_model(bus.cmd_op, bus.cmd_a, bus.cmd_b);
          cnt_d    = LAT_INIT;
          state_d  = S_WAIT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        // Count 1 means this edge is ALU_LAT cycles after the accept edge.
        if (cnt_q <= 4'd1) begin
          rsp_result_d   = alu_result_i;
          rsp_carry_d    = alu_carry_i;
          rsp_op_d       = alu_op_q;
          rsp_mismatch_d = mismatch_s;
          rsp_valid_d    = 1'b1;
          cnt_d          = 4'd0;
          state_d        = S_RESP;
        end else begin
          cnt_d          = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (rsp_mismatch_q && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            err_d = err_q;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset discards any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= 3'd0;
      exp_q          <= '0;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_op_q       <= 3'd0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_mismatch_q <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      exp_q          <= exp_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_op_q       <= rsp_op_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      err_q          <= err_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_op       = rsp_op_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_mismatch = rsp_mismatch_q;
  assign alu_a_o          = alu_a_q;
  assign alu_b_o          = alu_b_q;
  assign alu_op_o         = alu_op_q;
  assign err_count_o      = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: one instance with ALU_LAT=1
// (with an injectable stuck-at-1 fault on ALU result bit 0) and one with
// ALU_LAT=3 for the reset-while-waiting scenario.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] res;
    logic       c;
    logic       mm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  logic [7:0] err_model1 = 8'd0;
  logic fault1 = 1'b0;

  alu_cmd_sequencer_if #(.WIDTH(4)) if1 ();
  alu_cmd_sequencer_if #(.WIDTH(4)) if3 ();

  logic [3:0] alu1_a, alu1_b, alu1_res, alu3_a, alu3_b, alu3_res;
  logic [2:0] alu1_op, alu3_op;
  logic       alu1_c, alu3_c;
  logic [4:0] alu1_full, alu3_full;
  logic [7:0] err1, err3;

  // Independent arithmetic model of the ALU, returns {carry, result}.
  function automatic logic [4:0] tb_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0:    return 5'(ia + ib);
      3'd1:    return {(ia < ib) ? 1'b1 : 1'b0, 4'((ia - ib + 16) % 16)};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, 4'(15 - ia)};
      3'd6:    return {a[3], 4'((ia * 2) % 16)};
      3'd7:    return {a[0], 4'(ia / 2)};
      default: return 5'd0;
    endcase
  endfunction

  // Combinational ALUs in front of each sequencer; ALU 1 can be faulted.
  always_comb begin
    alu1_full = tb_ref(alu1_op, alu1_a, alu1_b);
    alu1_res  = alu1_full[3:0] | {3'b000, fault1};
    alu1_c    = alu1_full[4];
    alu3_full = tb_ref(alu3_op, alu3_a, alu3_b);
    alu3_res  = alu3_full[3:0];
    alu3_c    = alu3_full[4];
  end

  alu_cmd_sequencer #(.WIDTH(4), .ALU_LAT(1), .CHECK_CARRY(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(if1),
    .alu_a_o(alu1_a), .alu_b_o(alu1_b), .alu_op_o(alu1_op),
    .alu_result_i(alu1_res), .alu_carry_i(alu1_c), .err_count_o(err1)
  );

  alu_cmd_sequencer #(.WIDTH(4), .ALU_LAT(3), .CHECK_CARRY(1), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .bus(if3),
    .alu_a_o(alu3_a), .alu_b_o(alu3_b), .alu_op_o(alu3_op),
    .alu_result_i(alu3_res), .alu_carry_i(alu3_c), .err_count_o(err3)
  );

  // Offer a command to instance 1, push its expectation, return just after the accept edge.
  task automatic issue1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input bit keep);
    exp_t e;
    logic [4:0] full;
    bit ok;
    ok = 1'b0;
    if1.cmd_op = op; if1.cmd_a = a; if1.cmd_b = b; if1.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (if1.cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL accept_timeout: cmd_ready=%b required 1", if1.cmd_ready); end
    full  = tb_ref(op, a, b);
    e.op  = op;
    e.res = full[3:0] | {3'b000, fault1};
    e.c   = full[4];
    e.mm  = (e.res != full[3:0]);
    sb.push_back(e);
    @(posedge clk); #1;
    if (!keep) if1.cmd_valid = 1'b0;
  endtask

  // Wait for the response of instance 1, check latency and contents, complete the handshake.
  task automatic collect1(input int lat);
    exp_t e;
    int seen;
    seen = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if1.rsp_valid) begin seen = k; break; end
    end
    n_tests++;
    if (seen < 0) begin
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", if1.rsp_valid);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (seen != lat) begin n_fail++; $display("FAIL latency: got %0d required %0d", seen, lat); end
    e = sb.pop_front();
    n_tests++; if (if1.rsp_op !== e.op) begin n_fail++; $display("FAIL rsp_op: got %b required %b", if1.rsp_op, e.op); end
    n_tests++; if (if1.rsp_result !== e.res) begin n_fail++; $display("FAIL rsp_result: got %b required %b", if1.rsp_result, e.res); end
    n_tests++; if (if1.rsp_carry !== e.c) begin n_fail++; $display("FAIL rsp_carry: got %b required %b", if1.rsp_carry, e.c); end
    n_tests++; if (if1.rsp_mismatch !== e.mm) begin n_fail++; $display("FAIL rsp_mismatch: got %b required %b", if1.rsp_mismatch, e.mm); end
    @(posedge clk);
    if (e.mm && err_model1 != 8'hFF) err_model1 = err_model1 + 8'd1;
    @(negedge clk);
    n_tests++; if (if1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_valid_drop: got %b required 0", if1.rsp_valid); end
    n_tests++; if (err1 !== err_model1) begin n_fail++; $display("FAIL err_count: got %0d required %0d", err1, err_model1); end
  endtask

  task automatic test_reset();
    if1.cmd_valid = 1'b0; if1.rsp_ready = 1'b1; if1.cmd_a = 4'd0; if1.cmd_b = 4'd0; if1.cmd_op = 3'd0;
    if3.cmd_valid = 1'b0; if3.rsp_ready = 1'b1; if3.cmd_a = 4'd0; if3.cmd_b = 4'd0; if3.cmd_op = 3'd0;
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (if1.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", if1.cmd_ready); end
    n_tests++; if (if1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", if1.rsp_valid); end
    n_tests++; if ({alu1_a, alu1_b, alu1_op} !== 11'd0) begin n_fail++; $display("FAIL reset_alu: got %h required 0", {alu1_a, alu1_b, alu1_op}); end
    n_tests++; if ({if1.rsp_op, if1.rsp_result, if1.rsp_carry, if1.rsp_mismatch} !== 9'd0) begin n_fail++; $display("FAIL reset_rsp: got %h required 0", {if1.rsp_op, if1.rsp_result, if1.rsp_carry, if1.rsp_mismatch}); end
    n_tests++; if (err1 !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d required 0", err1); end
    n_tests++; if (if3.cmd_ready !== 1'b1 || if3.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dut3: ready=%b valid=%b required 1/0", if3.cmd_ready, if3.rsp_valid); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    issue1(3'b000, 4'b0011, 4'b0101, 1'b0);
    collect1(1);
  endtask

  task automatic test_boundaries();
    issue1(3'b000, 4'b1111, 4'b0001, 1'b0); collect1(1);
    issue1(3'b001, 4'b0011, 4'b0101, 1'b0); collect1(1);
    issue1(3'b110, 4'b1001, 4'b0000, 1'b0); collect1(1);
    issue1(3'b111, 4'b1100, 4'b0000, 1'b0); collect1(1);
  endtask

  task automatic test_all_ops();
    for (int i = 0; i < 24; i++) begin
      issue1(3'(i % 8), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      collect1(1);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4:0] full;
    bit got;
    if1.rsp_ready = 1'b0;
    issue1(3'b011, 4'b1010, 4'b0100, 1'b1);
    if1.cmd_op = 3'b000; if1.cmd_a = 4'b0110; if1.cmd_b = 4'b0111;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if1.rsp_valid) begin got = 1'b1; break; end
    end
    n_tests++; if (!got) begin n_fail++; $display("FAIL bp_rsp_timeout: rsp_valid=%b required 1", if1.rsp_valid); end
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (if1.rsp_result !== e.res || if1.rsp_op !== e.op || if1.rsp_carry !== e.c || if1.rsp_mismatch !== e.mm || if1.rsp_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: got v=%b op=%b r=%b c=%b m=%b required 1 %b %b %b %b",
                           if1.rsp_valid, if1.rsp_op, if1.rsp_result, if1.rsp_carry, if1.rsp_mismatch, e.op, e.res, e.c, e.mm);
      end
      n_tests++; if (if1.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready: got %b required 0", if1.cmd_ready); end
      n_tests++; if (alu1_a !== 4'b1010 || alu1_op !== 3'b011) begin n_fail++; $display("FAIL bp_no_accept: alu_a=%b op=%b required 1010 011", alu1_a, alu1_op); end
      @(negedge clk);
    end
    if1.rsp_ready = 1'b1;
    full = tb_ref(3'b000, 4'b0110, 4'b0111);
    e.op = 3'b000; e.res = full[3:0]; e.c = full[4]; e.mm = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (if1.rsp_valid !== 1'b0 || if1.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b ready=%b required 0/1", if1.rsp_valid, if1.cmd_ready); end
    @(posedge clk); #1;
    if1.cmd_valid = 1'b0;
    collect1(1);
  endtask

  task automatic test_fault();
    fault1 = 1'b1;
    issue1(3'b100, 4'b1100, 4'b1010, 1'b0);
    collect1(1);
    n_tests++; if (err1 !== 8'd1) begin n_fail++; $display("FAIL fault_err_first: got %0d required 1", err1); end
    for (int i = 1; i < 300; i++) begin
      issue1(3'b010, 4'b0000, 4'($urandom_range(0, 15)), 1'b0);
      collect1(1);
    end
    n_tests++; if (err1 !== 8'd255) begin n_fail++; $display("FAIL fault_err_saturate: got %0d required 255", err1); end
    fault1 = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int seen;
    if3.cmd_op = 3'b000; if3.cmd_a = 4'd7; if3.cmd_b = 4'd9; if3.cmd_valid = 1'b1; if3.rsp_ready = 1'b1;
    n_tests++; if (if3.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b required 1", if3.cmd_ready); end
    @(posedge clk); #1 if3.cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    err_model1 = 8'd0;
    n_tests++; if (if3.rsp_valid !== 1'b0 || if3.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rw_reset: valid=%b ready=%b required 0/1", if3.rsp_valid, if3.cmd_ready); end
    n_tests++; if (alu3_a !== 4'd0 || err1 !== 8'd0) begin n_fail++; $display("FAIL rw_clear: alu_a=%b err1=%0d required 0/0", alu3_a, err1); end
    @(negedge clk); rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if3.rsp_valid !== 1'b0) ok = 1'b0;
    end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rw_no_pulse: rsp_valid pulsed, required 0"); end
    if3.cmd_op = 3'b001; if3.cmd_a = 4'b0011; if3.cmd_b = 4'b0101; if3.cmd_valid = 1'b1;
    @(posedge clk); #1 if3.cmd_valid = 1'b0;
    seen = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if3.rsp_valid) begin seen = k; break; end
    end
    n_tests++; if (seen != 3) begin n_fail++; $display("FAIL rw_latency: got %0d required 3", seen); end
    n_tests++; if (if3.rsp_result !== 4'b1110 || if3.rsp_carry !== 1'b1 || if3.rsp_mismatch !== 1'b0 || if3.rsp_op !== 3'b001) begin
      n_fail++; $display("FAIL rw_rsp: op=%b r=%b c=%b m=%b required 001 1110 1 0", if3.rsp_op, if3.rsp_result, if3.rsp_carry, if3.rsp_mismatch);
    end
    @(posedge clk); @(negedge clk);
    n_tests++; if (if3.rsp_valid !== 1'b0 || err3 !== 8'd0) begin n_fail++; $display("FAIL rw_done: valid=%b err=%0d required 0/0", if3.rsp_valid, err3); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_boundaries();
    test_all_ops();
    test_back_to_back();
    test_fault();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
